shift_job_master: RTL

- Bus master that sits directly upstream of the shifter peripheral's register interface (reg_sel/cs/we/data_in/data_out).
- Accepts one shift job at a time over a valid/ready handshake and runs the full register sequence: write info, write original, start, timed wait, read result.
- Returns the shifted word on a valid/ready result channel.
- Frees the processor from sequencing the peripheral by hand.

---
 rtl/shift_pkg.sv | 35 +++
 rtl/shift_wait_timer.sv | 51 +++++
 rtl/shift_job_master.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_pkg
// Brief    : Shared constants and types for the shift job master and its
//            wait timer. Covers register map, direction encoding, FSM states
//            and the peripheral shift-count ceiling.
// Revision : 1.0 - initial release
// ============================================================================
package shift_pkg;

  // Peripheral register map
  localparam logic [1:0] REG_INFO   = 2'd0;
  localparam logic [1:0] REG_ORIG   = 2'd1;
  localparam logic [1:0] REG_RESULT = 2'd2;
  localparam logic [1:0] REG_READY  = 2'd3;

  // Direction bit carried in info[15]
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Shift count at which the peripheral saturates
  localparam int unsigned MAX_TIMES = 15;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_INFO = 3'd1,
    ST_WR_ORIG = 3'd2,
    ST_START   = 3'd3,
    ST_WAIT    = 3'd4,
    ST_READ    = 3'd5,
    ST_RESP    = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/shift_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : shift_wait_timer
// Brief    : 5-bit loadable down-counter. Loads min(amount, MAX_TIMES) +
//            margin, counts down while enabled, and flags done in the cycle
//            the count reads 1 (or 0, so a zero load can never stall).
// Revision : 1.0 - initial release
// ============================================================================
module shift_wait_timer #(
  parameter int unsigned MAX_TIMES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        en,
  input  logic [14:0] amount,
  input  logic [4:0]  margin,
  output logic        done
);

  logic [4:0] cnt_q;
  logic [4:0] cnt_d;
  logic [4:0] sat_amount;

  // Clamp the requested count the same way the peripheral does, then step the counter
  always_comb begin
    sat_amount = amount[4:0];
    if (amount > 15'(MAX_TIMES)) begin
      sat_amount = 5'(MAX_TIMES);
    end
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = sat_amount + margin;
    end else if (en && (cnt_q != 5'd0)) begin
      cnt_d = cnt_q - 5'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 5'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q <= 5'd1);

endmodule
`default_nettype wire

// File: rtl/shift_job_master.sv
`default_nettype none
// ============================================================================
// Module   : shift_job_master
// Brief    : Runs one shift job against the shifter peripheral: write info,
//            write original, strobe start, timed wait, read result, then
//            present the result on a valid/ready channel. All bus outputs are
//            registered from the next-state decode.
// Revision : 1.0 - initial release
// ============================================================================
module shift_job_master #(
  parameter int unsigned WAIT_MARGIN = 4,
  parameter int unsigned MAX_TIMES   = shift_pkg::MAX_TIMES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [15:0] job_value,
  input  logic [14:0] job_amount,
  input  logic        job_dir,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        busy,
  output logic        bus_cs,
  output logic        bus_we,
  output logic [1:0]  bus_reg_sel,
  output logic [15:0] bus_wdata,
  input  logic [15:0] bus_rdata
);

  import shift_pkg::*;

  state_t      state_q, state_d;
  logic [15:0] value_q, value_d;
  logic [14:0] amount_q, amount_d;
  logic        dir_q, dir_d;
  logic [15:0] res_data_q;
  logic        cs_q, cs_d;
  logic        we_q, we_d;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] wdata_q, wdata_d;
  logic        job_ready_q, job_ready_d;
  logic        busy_q, busy_d;
  logic        res_valid_q, res_valid_d;
  logic        wait_done;

  shift_wait_timer #(
    .MAX_TIMES (MAX_TIMES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (state_q == ST_START),
    .en     (state_q == ST_WAIT),
    .amount (amount_q),
    .margin (5'(WAIT_MARGIN)),
    .done   (wait_done)
  );

  // Next state, job latch, and next-cycle output decode of the next state
  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    amount_d = amount_q;
    dir_d    = dir_q;
    case (state_q)
      ST_IDLE: begin
        if (job_valid && job_ready_q) begin
          state_d  = ST_WR_INFO;
          value_d  = job_value;
          amount_d = job_amount;
          dir_d    = job_dir;
        end
      end
      ST_WR_INFO: state_d = ST_WR_ORIG;
      ST_WR_ORIG: state_d = ST_START;
      ST_START:   state_d = ST_WAIT;
      ST_WAIT:    if (wait_done) state_d = ST_READ;
      ST_READ:    state_d = ST_RESP;
      ST_RESP:    if (res_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    cs_d        = 1'b0;
    we_d        = 1'b0;
    sel_d       = REG_INFO;
    wdata_d     = 16'h0000;
    job_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    res_valid_d = (state_d == ST_RESP);
    case (state_d)
      ST_WR_INFO: begin
        cs_d    = 1'b1;
        we_d    = 1'b1;
        sel_d   = REG_INFO;
        wdata_d = {dir_d, amount_d};
      end
      ST_WR_ORIG: begin
        cs_d    = 1'b1;
        we_d    = 1'b1;
        sel_d   = REG_ORIG;
        wdata_d = value_d;
      end
      ST_START: begin
        cs_d  = 1'b1;
        sel_d = REG_READY;
      end
      ST_READ: begin
        cs_d  = 1'b1;
        sel_d = REG_RESULT;
      end
      default: begin
      end
    endcase
  end

  // State, job and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      value_q     <= 16'h0000;
      amount_q    <= 15'h0000;
      dir_q       <= DIR_LEFT;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= REG_INFO;
      wdata_q     <= 16'h0000;
      job_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      value_q     <= value_d;
      amount_q    <= amount_d;
      dir_q       <= dir_d;
      cs_q        <= cs_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      wdata_q     <= wdata_d;
      job_ready_q <= job_ready_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
    end
  end

  // Capture the peripheral result at the end of the READ cycle; held until the next READ
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_data_q <= 16'h0000;
    end else if (state_q == ST_READ) begin
      res_data_q <= bus_rdata;
    end
  end

  assign job_ready   = job_ready_q;
  assign busy        = busy_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign bus_cs      = cs_q;
  assign bus_we      = we_q;
  assign bus_reg_sel = sel_q;
  assign bus_wdata   = wdata_q;

endmodule
`default_nettype wire
